// File: rtl/shwr_memory_arb_if.sv
// Shower-memory arbiter bus: per-channel requests in,
// muxed memory access and grant status out.
interface shwr_memory_arb_if #(
  parameter int NCH = 2,
  parameter int AW  = 15
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic              MODE;
  logic [SW-1:0]     FSEL;
  logic [NCH-1:0]    REQ;
  logic [NCH*AW-1:0] ADDR_IN;
  logic [NCH-1:0]    ENA_IN;
  logic [NCH-1:0]    GNT;
  logic [AW-1:0]     ADDR;
  logic              ENA;
  logic [SW-1:0]     OWNER;
  logic              BUSY;

  modport master (
    output MODE, FSEL, REQ, ADDR_IN, ENA_IN,
    input  GNT, ADDR, ENA, OWNER, BUSY
  );

  modport slave (
    input  MODE, FSEL, REQ, ADDR_IN, ENA_IN,
    output GNT, ADDR, ENA, OWNER, BUSY
  );
endinterface

// File: rtl/shwr_memory_arb.sv
// Shower-memory arbiter: round-robin or forced owner,
// bounded hold time, one idle cycle between owners.
module shwr_memory_arb #(
  parameter int NCH      = 2,
  parameter int AW       = 15,
  parameter int HOLD_MAX = 16
) (
  input logic              CLK,
  input logic              RST_N,
  shwr_memory_arb_if.slave bus
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    SWITCH
  } state_t;

  state_t         state_q;
  logic [NCH-1:0] gnt_q;
  logic [AW-1:0]  addr_q;
  logic           ena_q;
  logic [SW-1:0]  owner_q;
  logic [SW-1:0]  ptr_q;
  logic           busy_q;
  logic [7:0]     cnt_q;
  logic [7:0]     cnt_d;
  logic           mode_q;
  logic [SW-1:0]  fsel_q;

  logic [NCH-1:0] elig;
  logic [NCH-1:0] cand;
  logic           found;
  logic [SW-1:0]  win;
  logic [NCH-1:0] win_oh;
  logic [NCH-1:0] own_oh;
  logic [AW-1:0]  own_addr;
  logic           own_ena;
  logic           own_req;
  logic           other;
  logic           cfg_chg;
  logic           expire;
  logic           leave;

  // Eligible channels: all, or only FSEL when forced
  always_comb begin
    elig = '0;
    for (int i = 0; i < NCH; i++) begin
      elig[i] = !bus.MODE || (bus.FSEL == SW'(i));
    end
  end

  assign cand = bus.REQ & elig;

  // Round-robin pick: lowest index above ptr, else wrap
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i] && (i <= int'(ptr_q))) begin
        found = 1'b1;
        win   = SW'(i);
      end
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i] && (i > int'(ptr_q))) begin
        found = 1'b1;
        win   = SW'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      win_oh[i] = found && (win == SW'(i));
    end
  end

  // Current owner's request, enable and address
  always_comb begin
    own_oh   = '0;
    own_addr = '0;
    own_ena  = 1'b0;
    own_req  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (owner_q == SW'(i)) begin
        own_oh[i] = 1'b1;
        own_addr  = bus.ADDR_IN[i*AW +: AW];
        own_ena   = bus.ENA_IN[i];
        own_req   = bus.REQ[i];
      end
    end
  end

  assign other   = |(cand & ~own_oh);
  assign cfg_chg = (bus.MODE != mode_q) ||
                   (bus.FSEL != fsel_q);
  assign cnt_d   = cnt_q + 8'd1;
  assign expire  = (cnt_d >= 8'(HOLD_MAX));
  assign leave   = !own_req || cfg_chg ||
                   (expire && other);

  // Arbitration FSM with registered bus outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      addr_q  <= '0;
      ena_q   <= 1'b0;
      owner_q <= '0;
      ptr_q   <= SW'(NCH - 1);
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      fsel_q  <= '0;
    end else begin
      case (state_q)
        IDLE, SWITCH: begin
          ena_q <= 1'b0;
          cnt_q <= '0;
          if (found) begin
            state_q <= OWN;
            gnt_q   <= win_oh;
            owner_q <= win;
            busy_q  <= 1'b1;
            mode_q  <= bus.MODE;
            fsel_q  <= bus.FSEL;
          end else begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        OWN: begin
          addr_q <= own_addr;
          if (leave) begin
            state_q <= SWITCH;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            ena_q   <= 1'b0;
            ptr_q   <= owner_q;
            cnt_q   <= '0;
          end else begin
            ena_q <= own_ena;
            cnt_q <= expire ? 8'd0 : cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          ena_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.GNT   = gnt_q;
  assign bus.ADDR  = addr_q;
  assign bus.ENA   = ena_q;
  assign bus.OWNER = owner_q;
  assign bus.BUSY  = busy_q;
endmodule

// File: tb/tb_shwr_memory_arb.sv
// Directed bench for shwr_memory_arb: 2-, 3- and
// 4-channel instances sharing one clock and reset.
module tb_shwr_memory_arb;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [1:0]  hold_exp [11] = '{
    2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
    2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01
  };
  logic [19:0] pat = 20'b1011_0011_1000_1101_0110;

  always #5 clk = ~clk;

  shwr_memory_arb_if #(.NCH(2), .AW(15)) ia ();
  shwr_memory_arb_if #(.NCH(4), .AW(15)) ib ();
  shwr_memory_arb_if #(.NCH(3), .AW(8))  ic ();

  shwr_memory_arb #(.NCH(2), .AW(15), .HOLD_MAX(4))
    dut_a (.CLK(clk), .RST_N(rst_n), .bus(ia));
  shwr_memory_arb #(.NCH(4), .AW(15), .HOLD_MAX(16))
    dut_b (.CLK(clk), .RST_N(rst_n), .bus(ib));
  shwr_memory_arb #(.NCH(3), .AW(8), .HOLD_MAX(2))
    dut_c (.CLK(clk), .RST_N(rst_n), .bus(ic));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    n_chk++;
    if (ia.GNT !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_gnt_a: got %b want 00", ia.GNT);
    end
    n_chk++;
    if (ia.ADDR !== 15'h0 || ia.ENA !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_addr_ena_a: got %h/%b want 0/0",
               ia.ADDR, ia.ENA);
    end
    n_chk++;
    if (ia.OWNER !== 1'b0 || ia.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_owner_busy_a: got %b/%b want 0/0",
               ia.OWNER, ia.BUSY);
    end
    n_chk++;
    if (ib.GNT !== 4'h0 || ib.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_b: got %b/%b want 0000/0",
               ib.GNT, ib.BUSY);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    ia.ADDR_IN = {15'h1BBB, 15'h0AAA};
    ia.ENA_IN  = 2'b11;
    ia.REQ     = 2'b11;
    tick;
    n_chk++;
    if (ia.GNT !== 2'b01 || ia.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_grant: got %b/%b want 01/1",
               ia.GNT, ia.BUSY);
    end
    n_chk++;
    if (ia.ENA !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_ena_lat: got %b want 0", ia.ENA);
    end
    tick;
    n_chk++;
    if (ia.ADDR !== 15'h0AAA || ia.ENA !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_addr0: got %h/%b want 0aaa/1",
               ia.ADDR, ia.ENA);
    end
    ia.REQ = 2'b10;
    tick;
    n_chk++;
    if (ia.GNT !== 2'b00 || ia.ENA !== 1'b0 ||
        ia.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_switch: got %b/%b/%b want 00/0/0",
               ia.GNT, ia.ENA, ia.BUSY);
    end
    tick;
    n_chk++;
    if (ia.GNT !== 2'b10 || ia.OWNER !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_grant1: got %b/%b want 10/1",
               ia.GNT, ia.OWNER);
    end
    tick;
    n_chk++;
    if (ia.ADDR !== 15'h1BBB || ia.ENA !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_addr1: got %h/%b want 1bbb/1",
               ia.ADDR, ia.ENA);
    end
  endtask

  task automatic test_hold;
    ia.REQ = 2'b00;
    tick;
    tick;
    n_chk++;
    if (ia.GNT !== 2'b00 || ia.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_idle: got %b/%b want 00/0",
               ia.GNT, ia.BUSY);
    end
    ia.REQ = 2'b11;
    for (int k = 0; k < 11; k++) begin
      tick;
      n_chk++;
      if (ia.GNT !== hold_exp[k]) begin
        n_fail++;
        $display("FAIL hold_seq[%0d]: got %b want %b",
                 k, ia.GNT, hold_exp[k]);
      end
    end
  endtask

  task automatic test_single;
    ia.REQ = 2'b00;
    tick;
    tick;
    ia.REQ = 2'b10;
    tick;
    n_chk++;
    if (ia.GNT !== 2'b10) begin
      n_fail++;
      $display("FAIL single_grant: got %b want 10", ia.GNT);
    end
    for (int k = 0; k < 20; k++) begin
      ia.ENA_IN = {pat[k], 1'b0};
      tick;
      n_chk++;
      if (ia.GNT !== 2'b10 || ia.ENA !== pat[k]) begin
        n_fail++;
        $display("FAIL single[%0d]: gnt %b ena %b want 10 %b",
                 k, ia.GNT, ia.ENA, pat[k]);
      end
    end
  endtask

  task automatic test_forced;
    ia.REQ = 2'b00;
    tick;
    tick;
    n_chk++;
    if (ia.ADDR !== 15'h1BBB || ia.ENA !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_addr_hold: got %h/%b want 1bbb/0",
               ia.ADDR, ia.ENA);
    end
    ia.ENA_IN = 2'b11;
    ia.MODE   = 1'b1;
    ia.FSEL   = 1'b1;
    ia.REQ    = 2'b11;
    tick;
    n_chk++;
    if (ia.GNT !== 2'b10) begin
      n_fail++;
      $display("FAIL forced_grant: got %b want 10", ia.GNT);
    end
    for (int k = 0; k < 6; k++) begin
      tick;
      n_chk++;
      if (ia.GNT !== 2'b10) begin
        n_fail++;
        $display("FAIL forced_hold[%0d]: got %b want 10",
                 k, ia.GNT);
      end
    end
    ia.FSEL = 1'b0;
    tick;
    n_chk++;
    if (ia.GNT !== 2'b00) begin
      n_fail++;
      $display("FAIL forced_switch: got %b want 00", ia.GNT);
    end
    tick;
    n_chk++;
    if (ia.GNT !== 2'b01 || ia.OWNER !== 1'b0) begin
      n_fail++;
      $display("FAIL forced_fsel0: got %b/%b want 01/0",
               ia.GNT, ia.OWNER);
    end
    ia.REQ  = 2'b00;
    ia.MODE = 1'b0;
    ic.MODE = 1'b1;
    ic.FSEL = 2'd2;
    ic.REQ  = 3'b111;
    tick;
    n_chk++;
    if (ic.GNT !== 3'b100 || ic.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL fsel2_c: got %b/%b want 100/1",
               ic.GNT, ic.BUSY);
    end
    ic.FSEL = 2'd3;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_chk++;
      if (ic.GNT !== 3'b000 || ic.BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL fsel_range[%0d]: got %b/%b want 000/0",
                 k, ic.GNT, ic.BUSY);
      end
    end
    ic.REQ = 3'b000;
  endtask

  task automatic test_reset_mid;
    ib.ADDR_IN = {15'h7444, 15'h3333, 15'h2222, 15'h1111};
    ib.ENA_IN  = 4'hF;
    ib.REQ     = 4'b0001;
    tick;
    n_chk++;
    if (ib.GNT !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_grant: got %b want 0001", ib.GNT);
    end
    tick;
    n_chk++;
    if (ib.ENA !== 1'b1 || ib.ADDR !== 15'h1111) begin
      n_fail++;
      $display("FAIL mid_access: got %b/%h want 1/1111",
               ib.ENA, ib.ADDR);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (ib.ENA !== 1'b0 || ib.GNT !== 4'h0 ||
        ib.ADDR !== 15'h0 || ib.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: %b %b %h %b want 0 0000 0 0",
               ib.ENA, ib.GNT, ib.ADDR, ib.BUSY);
    end
    ib.REQ = 4'b1010;
    tick;
    n_chk++;
    if (ib.GNT !== 4'h0 || ib.ENA !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_held: got %b/%b want 0000/0",
               ib.GNT, ib.ENA);
    end
    rst_n = 1'b1;
    tick;
    n_chk++;
    if (ib.GNT !== 4'b0010 || ib.OWNER !== 2'd1) begin
      n_fail++;
      $display("FAIL post_rst_grant: got %b/%0d want 0010/1",
               ib.GNT, ib.OWNER);
    end
    tick;
    n_chk++;
    if (ib.ADDR !== 15'h2222 || ib.ENA !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_addr: got %h/%b want 2222/1",
               ib.ADDR, ib.ENA);
    end
    ib.REQ = 4'b1000;
    tick;
    n_chk++;
    if (ib.GNT !== 4'h0) begin
      n_fail++;
      $display("FAIL b_switch: got %b want 0000", ib.GNT);
    end
    tick;
    n_chk++;
    if (ib.GNT !== 4'b1000 || ib.OWNER !== 2'd3) begin
      n_fail++;
      $display("FAIL b_grant3: got %b/%0d want 1000/3",
               ib.GNT, ib.OWNER);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ia.MODE    = 1'b0;
    ia.FSEL    = '0;
    ia.REQ     = '0;
    ia.ADDR_IN = '0;
    ia.ENA_IN  = '0;
    ib.MODE    = 1'b0;
    ib.FSEL    = '0;
    ib.REQ     = '0;
    ib.ADDR_IN = '0;
    ib.ENA_IN  = '0;
    ic.MODE    = 1'b0;
    ic.FSEL    = '0;
    ic.REQ     = '0;
    ic.ADDR_IN = '0;
    ic.ENA_IN  = '0;
    test_reset;
    test_basic;
    test_hold;
    test_single;
    test_forced;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
